// File: rtl/sn76489_sequencer_wb8.sv
// Wishbone command sequencer for the SN76489 PSG: queues data bytes and wait commands,
// replays them as PSG bus writes. Define SN76489_SEQ_IRQ_EN to build the low-watermark IRQ.
module sn76489_sequencer_wb8 #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TICK_DIVIDE = 1000
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [1:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    output logic       O_psg_stb,
    output logic       O_psg_we,
    output logic [7:0] O_psg_dat,
    input  logic       I_psg_ack,
    output logic       O_irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIVIDE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          overflow, pause;
    logic [7:0]    tick_cnt;
    logic [PW-1:0] presc;

    logic       wr_cyc, push_req, ctrl_wr, flush, full, empty, do_push, pop, busy;
    logic [8:0] head;
    logic [7:0] status;

    always_comb begin
        wr_cyc   = I_wb_stb & I_wb_we;
        push_req = wr_cyc & ~I_wb_adr[1];
        ctrl_wr  = wr_cyc & (I_wb_adr == 2'b10);
        flush    = ctrl_wr & I_wb_dat[0];
        full     = (level == LW'(FIFO_DEPTH));
        empty    = (level == '0);
        // Fullness is judged on the pre-pop level, so a push into a full FIFO drops even if a pop coincides
        do_push  = push_req & ~full & ~flush;
        pop      = (state == S_IDLE) & ~empty & ~pause & ~flush;
        head     = mem[rd_ptr];
        busy     = (state != S_IDLE) | ~empty;
        status   = {busy, overflow, empty, 5'(level)};
    end

    assign O_psg_we = O_psg_stb;

    always_ff @(posedge I_wb_clk) begin
        if (do_push) mem[wr_ptr] <= {I_wb_adr[0], I_wb_dat};
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            pause    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(do_push) - LW'(pop);
            end
            if (ctrl_wr) pause <= I_wb_dat[2];
            if (ctrl_wr && I_wb_dat[1]) overflow <= 1'b0;
            if (push_req && full && !flush) overflow <= 1'b1;
        end
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            O_wb_ack <= 1'b0;
            O_wb_dat <= 8'h00;
        end else begin
            O_wb_ack <= I_wb_stb;
            O_wb_dat <= (I_wb_stb && !I_wb_we && I_wb_adr == 2'b10) ? status : 8'h00;
        end
    end

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            state     <= S_IDLE;
            O_psg_stb <= 1'b0;
            O_psg_dat <= 8'h00;
            tick_cnt  <= 8'h00;
            presc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (!head[8]) begin
                            O_psg_dat <= head[7:0];
                            O_psg_stb <= 1'b1;
                            state     <= S_ISSUE;
                        end else if (head[7:0] != 8'h00) begin
                            tick_cnt <= head[7:0];
                            presc    <= PRESC_RELOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                // Flush is ignored here so the PSG never sees a truncated strobe
                S_ISSUE: begin
                    if (I_psg_ack) begin
                        O_psg_stb <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (presc == '0) begin
                        presc    <= PRESC_RELOAD;
                        tick_cnt <= tick_cnt - 8'd1;
                        if (tick_cnt == 8'd1) state <= S_IDLE;
                    end else begin
                        presc <= presc - PW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SN76489_SEQ_IRQ_EN
    logic irq_en;

    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            irq_en <= 1'b0;
            O_irq  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= I_wb_dat[3];
            O_irq <= irq_en & (level <= LW'(FIFO_DEPTH / 2));
        end
    end
`else
    assign O_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sn76489_sequencer_wb8.sv
// Directed bench for sn76489_sequencer_wb8 with a PSG responder of programmable ack delay.
module tb_sn76489_sequencer_wb8;
    localparam int TD = 4;
`ifdef SN76489_SEQ_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] adr;
    logic [7:0] dat;
    logic       stb, we;
    logic       wb_ack;
    logic [7:0] wb_rdat;
    logic       psg_stb, psg_we;
    logic [7:0] psg_dat;
    logic       psg_ack;
    logic       irq;

    sn76489_sequencer_wb8 #(.FIFO_DEPTH(16), .TICK_DIVIDE(TD)) dut (
        .I_wb_clk (clk),
        .I_reset  (rst),
        .I_wb_adr (adr),
        .I_wb_dat (dat),
        .I_wb_stb (stb),
        .I_wb_we  (we),
        .O_wb_ack (wb_ack),
        .O_wb_dat (wb_rdat),
        .O_psg_stb(psg_stb),
        .O_psg_we (psg_we),
        .O_psg_dat(psg_dat),
        .I_psg_ack(psg_ack),
        .O_irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    logic stb_prev = 1'b0;
    logic [7:0] dat_prev = 8'h00;
    logic [7:0] xfer_dat[$];
    int xfer_cyc[$];
    int rise_cyc[$];

    // Completed PSG transfers are logged on the edge where the DUT samples ack
    always @(posedge clk) begin
        if (psg_stb && psg_ack) begin
            xfer_dat.push_back(psg_dat);
            xfer_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (psg_stb && !stb_prev) rise_cyc.push_back(cyc);
        if (psg_we !== psg_stb) begin
            errors++;
            $display("FAIL psg_we_eq_stb: we=%b stb=%b", psg_we, psg_stb);
        end
        if (psg_stb && stb_prev && psg_dat !== dat_prev) begin
            errors++;
            $display("FAIL psg_dat_stable: got %02h held %02h", psg_dat, dat_prev);
        end
        stb_prev = psg_stb;
        dat_prev = psg_dat;
        if (psg_ack) begin
            psg_ack = 1'b0;
            ack_cnt = 0;
        end else if (psg_stb) begin
            ack_cnt++;
            if (ack_cnt > ack_delay) psg_ack = 1'b1;
        end else begin
            ack_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge
    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        adr = a; dat = d; stb = 1'b1; we = 1'b1;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d, output logic ack);
        adr = a; dat = 8'h00; stb = 1'b1; we = 1'b0;
        @(negedge clk);
        d = wb_rdat;
        ack = wb_ack;
        stb = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [7:0] exp);
        logic [7:0] s;
        logic a;
        wb_read(2'b10, s, a);
        check(name, {24'h0, s}, {24'h0, exp});
    endtask

    task automatic wait_idle(input int budget);
        logic [7:0] s;
        logic a;
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            wb_read(2'b10, s, a);
            if (!s[7] && !psg_stb) done = 1;
        end
        check("wait_idle_timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic clear_logs();
        xfer_dat.delete();
        xfer_cyc.delete();
        rise_cyc.delete();
    endtask

    typedef struct {
        bit         is_rd;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [7:0] rd;
        logic       rack;

        vecs[0]  = '{1'b1, 2'b10, 8'h00, 8'h20};
        vecs[1]  = '{1'b1, 2'b00, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 2'b11, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 2'b11, 8'hFF, 8'h00};
        vecs[4]  = '{1'b1, 2'b10, 8'h00, 8'h20};
        vecs[5]  = '{1'b0, 2'b10, 8'h04, 8'h00};
        vecs[6]  = '{1'b0, 2'b00, 8'h11, 8'h00};
        vecs[7]  = '{1'b0, 2'b00, 8'h22, 8'h00};
        vecs[8]  = '{1'b0, 2'b01, 8'h05, 8'h00};
        vecs[9]  = '{1'b1, 2'b10, 8'h00, 8'h83};
        vecs[10] = '{1'b1, 2'b01, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 2'b10, 8'h05, 8'h00};
        vecs[12] = '{1'b1, 2'b10, 8'h00, 8'h20};
        vecs[13] = '{1'b0, 2'b10, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 2'b10, 8'h00, 8'h20};

        rst = 1'b1; adr = 2'b00; dat = 8'h00; stb = 1'b0; we = 1'b0; psg_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wb_ack", {31'h0, wb_ack}, 32'h0);
        check("rst_wb_dat", {24'h0, wb_rdat}, 32'h0);
        check("rst_psg_stb", {31'h0, psg_stb}, 32'h0);
        check("rst_psg_dat", {24'h0, psg_dat}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Register-level vectors: decode, status fields, pause and flush with no PSG traffic
        clear_logs();
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_rd) begin
                wb_read(vecs[i].a, rd, rack);
                check($sformatf("vec%0d_rdat", i), {24'h0, rd}, {24'h0, vecs[i].exp});
                check($sformatf("vec%0d_ack", i), {31'h0, rack}, 32'h1);
            end else begin
                wb_write(vecs[i].a, vecs[i].d);
            end
        end
        repeat (4) @(negedge clk);
        check("vec_no_psg_writes", 32'(xfer_dat.size()), 32'h0);

        // Two data bytes back to back
        clear_logs();
        ack_delay = 1;
        wb_write(2'b00, 8'h9F);
        wb_write(2'b00, 8'hBF);
        wait_idle(40);
        check("t1_count", 32'(xfer_dat.size()), 32'd2);
        if (xfer_dat.size() == 2) begin
            check("t1_dat0", {24'h0, xfer_dat[0]}, 32'h9F);
            check("t1_dat1", {24'h0, xfer_dat[1]}, 32'hBF);
            check("t1_rise_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
            check("t1_stb_to_ack", 32'(xfer_cyc[0] - rise_cyc[0]), 32'd1);
        end
        check_status("t1_status", 8'h20);

        // Wait of 3 ticks between two data bytes
        clear_logs();
        wb_write(2'b00, 8'h80);
        wb_write(2'b01, 8'h03);
        wb_write(2'b00, 8'h05);
        wait_idle(60);
        check("t2_count", 32'(xfer_dat.size()), 32'd2);
        if (xfer_dat.size() == 2 && rise_cyc.size() == 2) begin
            check("t2_dat1", {24'h0, xfer_dat[1]}, 32'h05);
            check("t2_wait_cycles", 32'(rise_cyc[1] - xfer_cyc[0]), 32'(3 * TD + 3));
        end

        // Zero-length wait costs exactly one idle cycle
        clear_logs();
        wb_write(2'b00, 8'h11);
        wb_write(2'b01, 8'h00);
        wb_write(2'b00, 8'h22);
        wait_idle(40);
        check("t2b_count", 32'(xfer_dat.size()), 32'd2);
        if (xfer_dat.size() == 2 && rise_cyc.size() == 2)
            check("t2b_wait0_gap", 32'(rise_cyc[1] - xfer_cyc[0]), 32'd3);

        // Overflow: 17 pushes while paused, then clear and drain
        clear_logs();
        wb_write(2'b10, 8'h04);
        for (int i = 0; i < 17; i++) wb_write(2'b00, 8'(i));
        check_status("t3_status_full", 8'hD0);
        wb_write(2'b10, 8'h06);
        check_status("t3_status_cleared", 8'h90);
        check("t3_paused_no_writes", 32'(xfer_dat.size()), 32'h0);
        wb_write(2'b10, 8'h00);
        wait_idle(120);
        check("t3_count", 32'(xfer_dat.size()), 32'd16);
        if (xfer_dat.size() == 16) begin
            check("t3_first", {24'h0, xfer_dat[0]}, 32'h00);
            check("t3_last", {24'h0, xfer_dat[15]}, 32'h0F);
        end
        check_status("t3_status_end", 8'h20);

        // Flush during a slow ISSUE
        clear_logs();
        ack_delay = 5;
        wb_write(2'b00, 8'h11);
        wb_write(2'b00, 8'h22);
        wb_write(2'b00, 8'h33);
        wb_write(2'b10, 8'h01);
        check("t4_stb_held", {31'h0, psg_stb}, 32'h1);
        check_status("t4_status_issue", 8'hA0);
        wait_idle(30);
        repeat (10) @(negedge clk);
        check("t4_count", 32'(xfer_dat.size()), 32'd1);
        if (xfer_dat.size() == 1 && rise_cyc.size() == 1) begin
            check("t4_dat", {24'h0, xfer_dat[0]}, 32'h11);
            check("t4_stb_len", 32'(xfer_cyc[0] - rise_cyc[0]), 32'd5);
        end
        check_status("t4_status_end", 8'h20);

        // Flush aborts WAIT at once
        clear_logs();
        ack_delay = 1;
        wb_write(2'b01, 8'h0A);
        wb_write(2'b00, 8'h44);
        repeat (3) @(negedge clk);
        wb_write(2'b10, 8'h01);
        check_status("t4b_wait_abort", 8'h20);
        repeat (4) @(negedge clk);
        check("t4b_no_writes", 32'(xfer_dat.size()), 32'h0);

        // Asynchronous reset in the middle of WAIT, then of ISSUE
        clear_logs();
        wb_write(2'b01, 8'h05);
        repeat (3) @(negedge clk);
        check_status("t5_in_wait", 8'hA0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_status("t5_after_wait_rst", 8'h20);
        ack_delay = 5;
        wb_write(2'b00, 8'h55);
        @(negedge clk);
        check("t5_stb_before_rst", {31'h0, psg_stb}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("t5_stb_async_drop", {31'h0, psg_stb}, 32'h0);
        check("t5_dat_async_clear", {24'h0, psg_dat}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check_status("t5_after_issue_rst", 8'h20);
        repeat (8) @(negedge clk);
        check("t5_no_writes", 32'(xfer_dat.size()), 32'h0);

        // Low-watermark interrupt
        clear_logs();
        ack_delay = 1;
        wb_write(2'b10, 8'h0C);
        for (int i = 0; i < 9; i++) wb_write(2'b00, 8'(8'h20 + i));
        @(negedge clk);
        check("t6_irq_level9", {31'h0, irq}, 32'h0);
        wb_write(2'b10, 8'h08);
        check("t6_irq_unpause", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("t6_irq_pop_edge", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("t6_irq_level8", {31'h0, irq}, {31'h0, IRQ_BUILD});
        wait_idle(60);
        check("t6_count", 32'(xfer_dat.size()), 32'd9);
        check_status("t6_status_end", 8'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
